// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - forward-select codes driven on ForwardAE/ForwardBE
//   - state type for the multiply-hold FSM
package hazard_pkg;

  // Forward-select codes for the E-stage ALU operand muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from W stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from M stage ALU result

  // Multiply-hold FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/mul_stall_ctrl.sv
// mul_stall_ctrl: holds a multiply in the E stage for MUL_LAT cycles.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   MulE     in   E holds a valid multiply
//   PCSrcE   in   taken branch/jump resolved in E (suppresses a multiply start)
//   mulStall out  hold E this cycle (combinational from state and inputs)
//   MulBusy  out  FSM is in BUSY (registered state, doubles as state visibility)
//
// Sequence for one multiply: the IDLE cycle that sees MulE stalls and loads
// the down-counter with MUL_LAT-2; BUSY keeps stalling while the counter is
// non-zero; the BUSY cycle with the counter at zero is the release cycle in
// which the multiply advances to M. E is therefore occupied for exactly
// MUL_LAT cycles, the first MUL_LAT-1 of them stalled.
module mul_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic MulE,
  input  logic PCSrcE,
  output logic mulStall,
  output logic MulBusy
);

  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

  mul_state_t    state;
  logic [CW-1:0] cnt;
  logic          start;

  // A single-cycle multiplier never needs a hold; a branch in E squashes the
  // multiply, so it must not start a sequence either.
  assign start = (MUL_LAT >= 2) && (state == IDLE) && MulE && !PCSrcE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          // MulE and PCSrcE are ignored here: the multiply already owns E.
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign mulStall = !rst && (start || ((state == BUSY) && (cnt != '0)));
  assign MulBusy  = !rst && (state == BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard controller for the 5-stage core with a multi-cycle
// multiplier. Forwards from M/W, stalls on load-use, flushes on a taken
// branch/jump, holds E for the multiplier, and counts stall cycles.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   RegWriteM, RegWriteW     M/W write enables
//   RdM, RdW, RdE            destination registers
//   Rs1E, Rs2E, Rs1D, Rs2D   source registers
//   ResultSrcE0              E holds a load
//   MulE                     E holds a valid multiply
//   PCSrcE                   taken branch/jump in E
//   ForwardAE, ForwardBE     operand select (hazard_pkg FWD_* codes)
//   StallF, StallD, StallE   hold PC, IF/ID, ID/EX
//   FlushD, FlushE, FlushM   bubble into IF/ID, ID/EX, EX/MEM
//   MulBusy                  multiply FSM in BUSY
//   StallCnt                 saturating count of cycles with StallF=1
//
// All outputs except StallCnt are combinational; every output reads zero
// while rst is high.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              ResultSrcE0,
  input  logic              MulE,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MulBusy,
  output logic [CNT_W-1:0]  StallCnt
);

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       lw_stall;
  logic       mul_stall;
  logic       stall_any;

  // M is the younger result, so it wins over W; x0 is never forwarded.
  always_comb begin
    fwd_a = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
      fwd_a = FWD_MEM;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
      fwd_a = FWD_WB;
    end
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
      fwd_b = FWD_MEM;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
      fwd_b = FWD_WB;
    end
  end

  assign lw_stall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  mul_stall_ctrl #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_stall_ctrl (
    .clk      (clk),
    .rst      (rst),
    .MulE     (MulE),
    .PCSrcE   (PCSrcE),
    .mulStall (mul_stall),
    .MulBusy  (MulBusy)
  );

  assign stall_any = !rst && (lw_stall || mul_stall);

  assign ForwardAE = rst ? FWD_RF : fwd_a;
  assign ForwardBE = rst ? FWD_RF : fwd_b;
  assign StallF    = stall_any;
  assign StallD    = stall_any;
  assign StallE    = mul_stall;
  assign FlushD    = !rst && PCSrcE;
  // A held multiply keeps E intact, so it overrides a load-use/branch bubble.
  assign FlushE    = !rst && (lw_stall || PCSrcE) && !mul_stall;
  // While E is held, the EX/MEM register must take a bubble instead.
  assign FlushM    = mul_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
    end else if (stall_any && (StallCnt != {CNT_W{1'b1}})) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: table of combinational forwarding/load-use/branch
// vectors, then hand-written multi-cycle sequences for the multiply FSM,
// reset, and counter saturation. Three instances share the inputs:
// the default build, a MUL_LAT=1 build, and a CNT_W=4 build.
module tb_hazard_unit_mc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic       reg_write_m, reg_write_w;
  logic [4:0] rd_m, rd_w, rd_e, rs1_e, rs2_e, rs1_d, rs2_d;
  logic       result_src_e0, mul_e, pc_src_e;

  // main instance outputs
  logic [1:0]  fwd_a, fwd_b;
  logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mul_busy;
  logic [15:0] stall_cnt;

  // MUL_LAT=1 instance outputs
  logic [1:0]  l1_fwd_a, l1_fwd_b;
  logic        l1_stall_f, l1_stall_d, l1_stall_e, l1_flush_d, l1_flush_e, l1_flush_m, l1_mul_busy;
  logic [15:0] l1_stall_cnt;

  // CNT_W=4 instance outputs
  logic [1:0]  s4_fwd_a, s4_fwd_b;
  logic        s4_stall_f, s4_stall_d, s4_stall_e, s4_flush_d, s4_flush_e, s4_flush_m, s4_mul_busy;
  logic [3:0]  s4_stall_cnt;

  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .RdM(rd_m), .RdW(rd_w), .RdE(rd_e), .Rs1E(rs1_e), .Rs2E(rs2_e),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .ResultSrcE0(result_src_e0), .MulE(mul_e),
    .PCSrcE(pc_src_e), .ForwardAE(fwd_a), .ForwardBE(fwd_b), .StallF(stall_f),
    .StallD(stall_d), .StallE(stall_e), .FlushD(flush_d), .FlushE(flush_e),
    .FlushM(flush_m), .MulBusy(mul_busy), .StallCnt(stall_cnt)
  );

  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(1), .CNT_W(16)) dut_lat1 (
    .clk(clk), .rst(rst), .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .RdM(rd_m), .RdW(rd_w), .RdE(rd_e), .Rs1E(rs1_e), .Rs2E(rs2_e),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .ResultSrcE0(result_src_e0), .MulE(mul_e),
    .PCSrcE(pc_src_e), .ForwardAE(l1_fwd_a), .ForwardBE(l1_fwd_b), .StallF(l1_stall_f),
    .StallD(l1_stall_d), .StallE(l1_stall_e), .FlushD(l1_flush_d), .FlushE(l1_flush_e),
    .FlushM(l1_flush_m), .MulBusy(l1_mul_busy), .StallCnt(l1_stall_cnt)
  );

  hazard_unit_mc #(.REG_AW(5), .MUL_LAT(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .RdM(rd_m), .RdW(rd_w), .RdE(rd_e), .Rs1E(rs1_e), .Rs2E(rs2_e),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .ResultSrcE0(result_src_e0), .MulE(mul_e),
    .PCSrcE(pc_src_e), .ForwardAE(s4_fwd_a), .ForwardBE(s4_fwd_b), .StallF(s4_stall_f),
    .StallD(s4_stall_d), .StallE(s4_stall_e), .FlushD(s4_flush_d), .FlushE(s4_flush_e),
    .FlushM(s4_flush_m), .MulBusy(s4_mul_busy), .StallCnt(s4_stall_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    reg_write_m = 1'b0; reg_write_w = 1'b0;
    rd_m = '0; rd_w = '0; rd_e = '0;
    rs1_e = '0; rs2_e = '0; rs1_d = '0; rs2_d = '0;
    result_src_e0 = 1'b0; mul_e = 1'b0; pc_src_e = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rwm, rww;
    logic [4:0] rdm, rdw, rde, rs1e, rs2e, rs1d, rs2d;
    logic       ld, pc;
    logic [1:0] fa, fb;
    logic       sf, se, fd, fe;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(
    input logic rwm, input logic rww, input logic [4:0] rdm, input logic [4:0] rdw,
    input logic [4:0] rde, input logic [4:0] rs1e, input logic [4:0] rs2e,
    input logic [4:0] rs1d, input logic [4:0] rs2d, input logic ld, input logic pc,
    input logic [1:0] fa, input logic [1:0] fb, input logic sf, input logic se,
    input logic fd, input logic fe);
    vec_t v;
    v.rwm = rwm; v.rww = rww; v.rdm = rdm; v.rdw = rdw; v.rde = rde;
    v.rs1e = rs1e; v.rs2e = rs2e; v.rs1d = rs1d; v.rs2d = rs2d;
    v.ld = ld; v.pc = pc; v.fa = fa; v.fb = fb;
    v.sf = sf; v.se = se; v.fd = fd; v.fe = fe;
    return v;
  endfunction

  initial begin
    //               rwm   rww   rdm    rdw    rde    rs1e   rs2e   rs1d   rs2d   ld    pc      fa     fb     sf    se    fd    fe
    vecs[0]  = mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 5'd6, 5'd5, 5'd0, 5'd5, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd1, 5'd7, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd2, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
  end

  // ---------------- test sequence ----------------
  initial begin
    // Reset state with busy-looking inputs: everything must read zero.
    clear_inputs();
    reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5; rs2_e = 5'd5;
    pc_src_e = 1'b1; mul_e = 1'b1; result_src_e0 = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    #2;
    chk("rst_fwd_a",   32'(fwd_a), 32'd0);
    chk("rst_fwd_b",   32'(fwd_b), 32'd0);
    chk("rst_stall_f", 32'(stall_f), 32'd0);
    chk("rst_stall_e", 32'(stall_e), 32'd0);
    chk("rst_flush_d", 32'(flush_d), 32'd0);
    chk("rst_flush_e", 32'(flush_e), 32'd0);
    chk("rst_flush_m", 32'(flush_m), 32'd0);
    chk("rst_busy",    32'(mul_busy), 32'd0);
    chk("rst_cnt",     32'(stall_cnt), 32'd0);
    do_reset();

    // Table of single-cycle vectors (no multiply in E).
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      reg_write_m = vecs[i].rwm; reg_write_w = vecs[i].rww;
      rd_m = vecs[i].rdm; rd_w = vecs[i].rdw; rd_e = vecs[i].rde;
      rs1_e = vecs[i].rs1e; rs2_e = vecs[i].rs2e;
      rs1_d = vecs[i].rs1d; rs2_d = vecs[i].rs2d;
      result_src_e0 = vecs[i].ld; pc_src_e = vecs[i].pc; mul_e = 1'b0;
      #2;
      chk($sformatf("v%0d_fwd_a", i),   32'(fwd_a),   32'(vecs[i].fa));
      chk($sformatf("v%0d_fwd_b", i),   32'(fwd_b),   32'(vecs[i].fb));
      chk($sformatf("v%0d_stall_f", i), 32'(stall_f), 32'(vecs[i].sf));
      chk($sformatf("v%0d_stall_d", i), 32'(stall_d), 32'(vecs[i].sf));
      chk($sformatf("v%0d_stall_e", i), 32'(stall_e), 32'(vecs[i].se));
      chk($sformatf("v%0d_flush_d", i), 32'(flush_d), 32'(vecs[i].fd));
      chk($sformatf("v%0d_flush_e", i), 32'(flush_e), 32'(vecs[i].fe));
      chk($sformatf("v%0d_flush_m", i), 32'(flush_m), 32'd0);
    end

    // Single multiply, MUL_LAT=4, MulE held through the release cycle.
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      mul_e = 1'b1;
      #2;
      chk($sformatf("mul_c%0d_stall_e", c), 32'(stall_e),  32'(c <= 3));
      chk($sformatf("mul_c%0d_stall_f", c), 32'(stall_f),  32'(c <= 3));
      chk($sformatf("mul_c%0d_flush_m", c), 32'(flush_m),  32'(c <= 3));
      chk($sformatf("mul_c%0d_flush_e", c), 32'(flush_e),  32'd0);
      chk($sformatf("mul_c%0d_busy", c),    32'(mul_busy), 32'(c >= 2));
      chk($sformatf("mul_c%0d_cnt", c),     32'(stall_cnt), 32'(c - 1));
      chk($sformatf("lat1_c%0d_stall_e", c), 32'(l1_stall_e),  32'd0);
      chk($sformatf("lat1_c%0d_busy", c),    32'(l1_mul_busy), 32'd0);
    end
    @(negedge clk);
    mul_e = 1'b0;
    #2;
    chk("mul_done_busy", 32'(mul_busy), 32'd0);
    chk("mul_done_cnt",  32'(stall_cnt), 32'd3);
    chk("lat1_cnt",      32'(l1_stall_cnt), 32'd0);

    // Back-to-back multiplies: MulE high for 8 cycles.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mul_e = 1'b1;
      #2;
      chk($sformatf("b2b_c%0d_stall_e", c), 32'(stall_e), 32'((c % 4) != 3));
    end
    @(negedge clk);
    mul_e = 1'b0;
    #2;
    chk("b2b_cnt",  32'(stall_cnt), 32'd6);
    chk("b2b_busy", 32'(mul_busy), 32'd0);

    // Branch beats a multiply arriving in IDLE.
    do_reset();
    @(negedge clk);
    mul_e = 1'b1; pc_src_e = 1'b1;
    #2;
    chk("br_flush_d", 32'(flush_d), 32'd1);
    chk("br_flush_e", 32'(flush_e), 32'd1);
    chk("br_stall_e", 32'(stall_e), 32'd0);
    chk("br_stall_f", 32'(stall_f), 32'd0);
    chk("br_flush_m", 32'(flush_m), 32'd0);
    @(negedge clk);
    mul_e = 1'b0; pc_src_e = 1'b0;
    #2;
    chk("br_busy", 32'(mul_busy), 32'd0);
    chk("br_cnt",  32'(stall_cnt), 32'd0);

    // Reset asserted asynchronously in the 2nd stall cycle.
    do_reset();
    @(negedge clk);
    mul_e = 1'b1;
    @(negedge clk);
    mul_e = 1'b0;
    #2;
    chk("rmid_pre_stall_e", 32'(stall_e), 32'd1);
    chk("rmid_pre_busy",    32'(mul_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmid_stall_e", 32'(stall_e), 32'd0);
    chk("rmid_stall_f", 32'(stall_f), 32'd0);
    chk("rmid_flush_m", 32'(flush_m), 32'd0);
    chk("rmid_busy",    32'(mul_busy), 32'd0);
    chk("rmid_cnt",     32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rmid_after_busy",    32'(mul_busy), 32'd0);
    chk("rmid_after_stall_e", 32'(stall_e), 32'd0);
    @(negedge clk);
    #2;
    chk("rmid_after2_busy", 32'(mul_busy), 32'd0);
    chk("rmid_after2_cnt",  32'(stall_cnt), 32'd0);

    // Counter saturation: 20 load-use stall cycles.
    do_reset();
    @(negedge clk);
    result_src_e0 = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
    repeat (20) @(negedge clk);
    #2;
    chk("sat_cnt4",  32'(s4_stall_cnt), 32'd15);
    chk("sat_cnt16", 32'(stall_cnt), 32'd20);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
